solver_dispatch: RTL and testbench
==================================

# solver_dispatch

Host-side counterpart of the solver control's c-loading port. Buffers one complex point c (real and imaginary parts as arbitrary-precision limb arrays) written by the host. Streams it limb-serially into a solver over the `c_val`/`c_rdy` handshake. Then waits for the solver's iteration count and hands it back to the host over a val/rdy result port. One dispatcher drives exactly one solver; one job is in flight at a time.

## Interface
- `LIMB_BITS`, 32, width of one limb.
- `LIMB_INDEX_BITS`, 6, limb index width; buffer depth is 2^LIMB_INDEX_BITS limbs per component.
- `TIMEOUT_CYCLES`, 65535, watchdog limit; used only when the timeout feature is compiled in.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  host limb write strobe.
- `wr_addr`  in  LIMB_INDEX_BITS  limb index written (0 = least-significant limb).
- `wr_re`, `wr_im`  in  LIMB_BITS  real/imag limb data.
- `start_val`  in  1  host requests dispatch.
- `start_num_limbs`  in  LIMB_INDEX_BITS  limbs per component, valid with `start_val`.
- `start_rdy`  out  1  high only in IDLE.
- `c_val`  out  1  limb stream valid to solver.
- `c_rdy`  in  1  solver accepting limbs.
- `c_re`, `c_im`  out  LIMB_BITS  current limb.
- `limb_ind`  out  LIMB_INDEX_BITS  index of current limb.
- `iter_val`  in  1  solver result strobe.
- `iter_count`  in  16  solver iteration count.
- `res_val`  out  1  result valid to host.
- `res_rdy`  in  1  host accepts result.
- `res_count`  out  16  returned iteration count.
- `res_timeout`  out  1  result produced by the watchdog (0 when the feature is compiled out).

## Operation
- The buffer is two register arrays, `re_mem` and `im_mem`, each 2^LIMB_INDEX_BITS x LIMB_BITS.
  - The buffer is not cleared by reset.
  - A write commits at the clock edge only when `wr_en` and state == IDLE. Writes in any other state are dropped.
- The state machine has four states: IDLE, SEND, WAIT_RESULT, OUTPUT.
- **IDLE:**
  - `start_rdy`=1.
  - Acceptance of `start_val` requires `start_num_limbs`!=0. On acceptance: latch `num_limbs`, set `send_idx`=0, go to SEND.
  - `start_val` with `start_num_limbs`=0 is ignored, and the block stays in IDLE.
- **SEND:**
  - `c_val`=1. `c_re`=`re_mem[send_idx]`, `c_im`=`im_mem[send_idx]`, `limb_ind`=`send_idx` (combinational read of the buffer).
  - Each cycle with `c_rdy`=1 transfers one limb and increments `send_idx`.
  - When the transferred limb has `send_idx`==`num_limbs`-1, go to WAIT_RESULT. `c_val` falls on the following cycle; this falling edge is the end-of-c marker.
  - Cycles with `c_rdy`=0 hold all limb outputs stable.
- **WAIT_RESULT:**
  - `c_val`=0.
  - On `iter_val`=1: capture `iter_count` into `res_count`, clear `res_timeout`, go to OUTPUT.
  - `iter_val` in any other state is ignored.
- **OUTPUT:**
  - `res_val`=1. `res_count` and `res_timeout` are held stable.
  - On `res_rdy`=1: go to IDLE.
- `send_idx` never wraps: the maximum `num_limbs` is 2^LIMB_INDEX_BITS-1, so the highest index used is 2^LIMB_INDEX_BITS-2.

## Timing
- Reset values:
  - State IDLE, so `start_rdy`=1.
  - `c_val`=0, `limb_ind`=0.
  - `res_val`=0, `res_count`=0, `res_timeout`=0.
  - `c_re`/`c_im` follow `re_mem[0]`/`im_mem[0]`.
- Reset mid-operation aborts the job. The next cycle is IDLE, and `c_val` drops immediately.
- Start is accepted at edge T. `c_val`=1 with limb 0 is visible in cycle T+1.
  - With `c_rdy` held high, limb k is visible in cycle T+1+k.
  - `c_val` is low from cycle T+1+`num_limbs` onward.
- `iter_val` at edge R gives `res_val`=1 in cycle R+1. The `res_rdy` handshake at edge H gives `start_rdy`=1 in cycle H+1.
- Back-to-back jobs: the earliest new start is accepted at edge H+1.
- A host write and start in the same IDLE cycle: the write commits, and the dispatched job sees the new data.

## Configuration
- `SOLVER_DISPATCH_TIMEOUT_EN` defined:
  - A 16-bit watchdog counter clears on entry to WAIT_RESULT and increments every WAIT_RESULT cycle.
  - If it reaches `TIMEOUT_CYCLES` before `iter_val` arrives, the block goes to OUTPUT with `res_count`=16'hFFFF and `res_timeout`=1.
  - `iter_val` in the same cycle as expiry wins: the real count is returned and `res_timeout`=0.
- Not defined: no counter is built, `res_timeout` is tied to 0, and WAIT_RESULT waits indefinitely.

## Test plan
- **Reset values:** reset for 2 cycles, then release -> `start_rdy`=1, `c_val`=0, `res_val`=0, `res_count`=0.
- **Basic job:**
  - Write `re`=32'h1000_0000+i and `im`=32'h2000_0000+i for i=0..3. Start with `num_limbs`=4, `c_rdy`=1 constant.
  - Required: limbs 0..3 appear on consecutive cycles with `limb_ind`=0..3, then `c_val` falls.
  - Drive `iter_val` with `iter_count`=16'd57 -> `res_val`=1 with `res_count`=57. `res_rdy` -> IDLE.
- **Backpressure:** `num_limbs`=3, `c_rdy` pattern 1,0,0,1,1 -> limb 1 is held for 3 cycles. Exactly 3 transfers occur, then `c_val`=0.
- **Illegal and ignored inputs:**
  - Start with `num_limbs`=0 -> stays IDLE, `c_val` never rises.
  - `wr_en` during SEND -> memory unchanged; verify with a re-dispatch.
  - `iter_val` during SEND -> ignored.
- **Reset mid-SEND:** reset after limb 1 of 5 -> next cycle `c_val`=0, `start_rdy`=1. A new start resends from limb 0.
- **Timeout** (`SOLVER_DISPATCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=10): no `iter_val` -> `res_val` 10 cycles after entering WAIT_RESULT, with `res_count`=16'hFFFF and `res_timeout`=1.

Source files
------------

// File: rtl/solver_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : solver_dispatch
// Purpose  : Host-side c-loader for one solver. It buffers a complex point c
//            as two limb arrays and streams it limb-serially to the solver.
//            It then returns the solver's iteration count to the host over a
//            val/rdy port.
// Options  : SOLVER_DISPATCH_TIMEOUT_EN adds a watchdog on the result wait.
// Revision : 1.0 - initial release
// ============================================================================
module solver_dispatch #(
  parameter int LIMB_BITS       = 32,
  parameter int LIMB_INDEX_BITS = 6,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [LIMB_INDEX_BITS-1:0] wr_addr,
  input  logic [LIMB_BITS-1:0]       wr_re,
  input  logic [LIMB_BITS-1:0]       wr_im,
  input  logic                       start_val,
  input  logic [LIMB_INDEX_BITS-1:0] start_num_limbs,
  output logic                       start_rdy,
  output logic                       c_val,
  input  logic                       c_rdy,
  output logic [LIMB_BITS-1:0]       c_re,
  output logic [LIMB_BITS-1:0]       c_im,
  output logic [LIMB_INDEX_BITS-1:0] limb_ind,
  input  logic                       iter_val,
  input  logic [15:0]                iter_count,
  output logic                       res_val,
  input  logic                       res_rdy,
  output logic [15:0]                res_count,
  output logic                       res_timeout
);

  localparam int                       DEPTH   = 1 << LIMB_INDEX_BITS;
  localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE = {{(LIMB_INDEX_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND        = 2'd1,
    WAIT_RESULT = 2'd2,
    OUTPUT      = 2'd3
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [LIMB_BITS-1:0]         re_mem [DEPTH];
  logic [LIMB_BITS-1:0]         im_mem [DEPTH];
  logic [LIMB_INDEX_BITS-1:0]   num_limbs;
  logic [LIMB_INDEX_BITS-1:0]   send_idx;
  logic                         accept_start;
  logic                         transfer;
  logic                         last_xfer;
  logic                         result_in;
  logic                         timeout_hit;

  assign accept_start = (state == IDLE) && start_val && (start_num_limbs != '0);
  assign transfer     = (state == SEND) && c_rdy;
  assign last_xfer    = transfer && (send_idx == (num_limbs - IDX_ONE));
  assign result_in    = (state == WAIT_RESULT) && iter_val;

  // Limb stream reads the buffer combinationally at the current send index.
  assign c_re     = re_mem[send_idx];
  assign c_im     = im_mem[send_idx];
  assign limb_ind = send_idx;

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_count;

  // Watchdog: zeroed when WAIT_RESULT is entered, counts each cycle spent there.
  always_ff @(posedge clock) begin
    if (reset || last_xfer) begin
      wd_count <= '0;
    end else if (state == WAIT_RESULT) begin
      wd_count <= wd_count + 16'd1;
    end
  end

  // The expiry cycle is the last waiting cycle; a real result in it still wins.
  assign timeout_hit = (state == WAIT_RESULT) && !iter_val && (wd_count == WD_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  // Host writes land only while idle so an in-flight job never sees torn data.
  always_ff @(posedge clock) begin
    if (wr_en && (state == IDLE)) begin
      re_mem[wr_addr] <= wr_re;
      im_mem[wr_addr] <= wr_im;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    start_rdy  = 1'b0;
    c_val      = 1'b0;
    res_val    = 1'b0;
    case (state)
      IDLE: begin
        start_rdy = 1'b1;
        if (accept_start) state_next = SEND;
      end
      SEND: begin
        c_val = 1'b1;
        if (last_xfer) state_next = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (result_in || timeout_hit) state_next = OUTPUT;
      end
      OUTPUT: begin
        res_val = 1'b1;
        if (res_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job datapath: limb count, send pointer and the returned result.
  always_ff @(posedge clock) begin
    if (reset) begin
      num_limbs   <= '0;
      send_idx    <= '0;
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept_start) begin
        num_limbs <= start_num_limbs;
        send_idx  <= '0;
      end
      if (transfer) begin
        send_idx <= send_idx + IDX_ONE;
      end
      if (result_in) begin
        res_count   <= iter_count;
        res_timeout <= 1'b0;
      end else if (timeout_hit) begin
        res_count   <= 16'hFFFF;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_solver_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_solver_dispatch
// Purpose  : Directed self-checking bench for solver_dispatch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solver_dispatch;

  localparam int LB = 32;
  localparam int IB = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [IB-1:0] wr_addr;
  logic [LB-1:0] wr_re, wr_im;
  logic          start_val;
  logic [IB-1:0] start_num_limbs;
  logic          start_rdy;
  logic          c_val, c_rdy;
  logic [LB-1:0] c_re, c_im;
  logic [IB-1:0] limb_ind;
  logic          iter_val;
  logic [15:0]   iter_count;
  logic          res_val, res_rdy;
  logic [15:0]   res_count;
  logic          res_timeout;

  int n_cmp = 0;
  int n_err = 0;

  solver_dispatch #(
    .LIMB_BITS(LB), .LIMB_INDEX_BITS(IB), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re), .wr_im(wr_im),
    .start_val(start_val), .start_num_limbs(start_num_limbs), .start_rdy(start_rdy),
    .c_val(c_val), .c_rdy(c_rdy), .c_re(c_re), .c_im(c_im), .limb_ind(limb_ind),
    .iter_val(iter_val), .iter_count(iter_count),
    .res_val(res_val), .res_rdy(res_rdy), .res_count(res_count), .res_timeout(res_timeout)
  );

  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_limb(input int a, input logic [LB-1:0] re, input logic [LB-1:0] im);
    wr_en = 1'b1; wr_addr = IB'(a); wr_re = re; wr_im = im;
    tick;
    wr_en = 1'b0;
  endtask

  task automatic start_job(input int n);
    start_val = 1'b1; start_num_limbs = IB'(n);
    tick;
    start_val = 1'b0;
  endtask

  // Streams n limbs with c_rdy held high, checking each against the buffer image.
  task automatic expect_stream(input string tag, input int n, input logic [LB-1:0] base0);
    c_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      check_eq({tag, "_cval"}, 64'(c_val), 64'd1);
      check_eq({tag, "_ind"},  64'(limb_ind), 64'(k));
      check_eq({tag, "_re"},   64'(c_re), 64'((k == 0) ? base0 : 32'h1000_0000 + k));
      check_eq({tag, "_im"},   64'(c_im), 64'(32'h2000_0000 + k));
      tick;
    end
    check_eq({tag, "_end"}, 64'(c_val), 64'd0);
  endtask

  // Returns a result and hands it back to the host.
  task automatic finish_job(input string tag, input logic [15:0] cnt);
    iter_val = 1'b1; iter_count = cnt;
    tick;
    iter_val = 1'b0;
    check_eq({tag, "_resval"}, 64'(res_val), 64'd1);
    check_eq({tag, "_count"},  64'(res_count), 64'(cnt));
    check_eq({tag, "_tmo"},    64'(res_timeout), 64'd0);
    res_rdy = 1'b1;
    tick;
    res_rdy = 1'b0;
    check_eq({tag, "_idle"},   64'(start_rdy), 64'd1);
    check_eq({tag, "_resdn"},  64'(res_val), 64'd0);
  endtask

  initial begin
    logic [4:0] pat;
    int         exp_idx;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
    start_val = 1'b0; start_num_limbs = '0; c_rdy = 1'b0;
    iter_val = 1'b0; iter_count = '0; res_rdy = 1'b0;

    // Reset values
    tick; tick;
    reset = 1'b0;
    check_eq("rst_start_rdy", 64'(start_rdy), 64'd1);
    check_eq("rst_c_val",     64'(c_val), 64'd0);
    check_eq("rst_res_val",   64'(res_val), 64'd0);
    check_eq("rst_res_count", 64'(res_count), 64'd0);
    check_eq("rst_limb_ind",  64'(limb_ind), 64'd0);
    check_eq("rst_res_tmo",   64'(res_timeout), 64'd0);

    // Basic job
    for (int i = 0; i < 5; i++) write_limb(i, 32'h1000_0000 + i, 32'h2000_0000 + i);
    c_rdy = 1'b1;
    start_job(4);
    expect_stream("basic", 4, 32'h1000_0000);
    check_eq("basic_wait_rdy", 64'(start_rdy), 64'd0);
    finish_job("basic", 16'd57);

    // Backpressure, with a stray iter_val while sending
    pat = 5'b11001;                  // bit p is c_rdy in SEND cycle p: 1,0,0,1,1
    exp_idx = 0;
    start_job(3);
    for (int p = 0; p < 5; p++) begin
      c_rdy    = pat[p];
      iter_val = (p == 1);
      iter_count = 16'd99;
      check_eq("bp_cval", 64'(c_val), 64'd1);
      check_eq("bp_ind",  64'(limb_ind), 64'(exp_idx));
      check_eq("bp_re",   64'(c_re), 64'(32'h1000_0000 + exp_idx));
      if (pat[p]) exp_idx++;
      tick;
    end
    iter_val = 1'b0;
    check_eq("bp_xfers", 64'(limb_ind), 64'd3);
    check_eq("bp_end",   64'(c_val), 64'd0);
    check_eq("bp_noiter", 64'(res_val), 64'd0);
    finish_job("bp", 16'd33);

    // Start with zero limbs is ignored
    start_job(0);
    check_eq("zero_rdy",  64'(start_rdy), 64'd1);
    check_eq("zero_cval", 64'(c_val), 64'd0);
    tick;
    check_eq("zero_cval2", 64'(c_val), 64'd0);

    // Writes during SEND are dropped
    c_rdy = 1'b0;
    start_job(2);
    wr_en = 1'b1; wr_addr = '0; wr_re = 32'hDEAD_BEEF; wr_im = 32'hDEAD_BEEF;
    tick;
    wr_en = 1'b0;
    check_eq("wsend_hold_ind", 64'(limb_ind), 64'd0);
    check_eq("wsend_hold_re",  64'(c_re), 64'h1000_0000);
    expect_stream("wsend", 2, 32'h1000_0000);
    finish_job("wsend", 16'd5);
    start_job(1);
    expect_stream("wredisp", 1, 32'h1000_0000);
    finish_job("wredisp", 16'd6);

    // Write and start in the same idle cycle: the job sees the new data
    wr_en = 1'b1; wr_addr = '0; wr_re = 32'h3000_0000; wr_im = 32'h2000_0000;
    start_job(1);
    wr_en = 1'b0;
    expect_stream("wrst", 1, 32'h3000_0000);
    finish_job("wrst", 16'd7);

    // Reset mid-SEND aborts, then a fresh start resends from limb 0
    c_rdy = 1'b1;
    start_job(5);
    tick;
    check_eq("rmid_ind1", 64'(limb_ind), 64'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("rmid_cval", 64'(c_val), 64'd0);
    check_eq("rmid_rdy",  64'(start_rdy), 64'd1);
    check_eq("rmid_ind",  64'(limb_ind), 64'd0);
    start_job(5);
    expect_stream("rmid", 5, 32'h3000_0000);
    finish_job("rmid", 16'hFFFE);

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
    // Watchdog: no result for 10 waiting cycles
    start_job(1);
    tick;
    for (int j = 0; j < 10; j++) begin
      check_eq("tmo_wait", 64'(res_val), 64'd0);
      tick;
    end
    check_eq("tmo_resval", 64'(res_val), 64'd1);
    check_eq("tmo_count",  64'(res_count), 64'hFFFF);
    check_eq("tmo_flag",   64'(res_timeout), 64'd1);
    res_rdy = 1'b1;
    tick;
    res_rdy = 1'b0;
    check_eq("tmo_idle", 64'(start_rdy), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
